// File: rtl/rat_ckpt_if.sv
// Rename / commit / checkpoint signal bundle of the register alias table rat_ckpt.
// master = rename+commit side driving the table, slave = the table itself.
interface rat_ckpt_if #(
  parameter int ARCH_REG_NUM  = 32,
  parameter int PHY_REG_NUM   = 64,
  parameter int RENAME_WIDTH  = 4,
  parameter int COMMIT_WIDTH  = 4,
  parameter int READ_PORT_NUM = 3,
  parameter int CKPT_NUM      = 4
);
  localparam int AW = $clog2(ARCH_REG_NUM);
  localparam int PW = $clog2(PHY_REG_NUM);
  localparam int CW = $clog2(CKPT_NUM);

  logic [RENAME_WIDTH*PW-1:0]               new_phy_id;
  logic [RENAME_WIDTH-1:0]                  new_phy_id_valid;
  logic [RENAME_WIDTH*PW-1:0]               rename_phy_id;
  logic [RENAME_WIDTH-1:0]                  rename_phy_id_valid;
  logic [RENAME_WIDTH*AW-1:0]               rename_arch_id;
  logic                                     rename_map;
  logic [RENAME_WIDTH*READ_PORT_NUM*AW-1:0] read_arch_id;
  logic [RENAME_WIDTH*READ_PORT_NUM*PW-1:0] read_phy_id;
  logic [PHY_REG_NUM-1:0]                   map_table_valid;
  logic [PHY_REG_NUM-1:0]                   map_table_visible;
  logic [COMMIT_WIDTH*PW-1:0]               commit_phy_id;
  logic [COMMIT_WIDTH-1:0]                  commit_phy_id_valid;
  logic                                     commit_map;
  logic [COMMIT_WIDTH*PW-1:0]               release_phy_id;
  logic [COMMIT_WIDTH-1:0]                  release_phy_id_valid;
  logic                                     release_map;
  logic [PW-1:0]                            restore_new_phy_id;
  logic [PW-1:0]                            restore_old_phy_id;
  logic                                     restore_map;
  logic [PHY_REG_NUM-1:0]                   tbl_valid_in;
  logic [PHY_REG_NUM-1:0]                   tbl_visible_in;
  logic                                     tbl_restore;
  logic                                     ckpt_save;
  logic                                     ckpt_save_ready;
  logic [CW-1:0]                            ckpt_save_id;
  logic                                     ckpt_restore;
  logic [CW-1:0]                            ckpt_restore_id;
  logic                                     ckpt_free;
  logic [CW-1:0]                            ckpt_free_id;
  logic [CKPT_NUM-1:0]                      ckpt_busy;
  logic                                     consistency_err;

  modport master (
    input  new_phy_id, new_phy_id_valid, read_phy_id, map_table_valid, map_table_visible,
           ckpt_save_ready, ckpt_save_id, ckpt_busy, consistency_err,
    output rename_phy_id, rename_phy_id_valid, rename_arch_id, rename_map, read_arch_id,
           commit_phy_id, commit_phy_id_valid, commit_map,
           release_phy_id, release_phy_id_valid, release_map,
           restore_new_phy_id, restore_old_phy_id, restore_map,
           tbl_valid_in, tbl_visible_in, tbl_restore,
           ckpt_save, ckpt_restore, ckpt_restore_id, ckpt_free, ckpt_free_id
  );

  modport slave (
    output new_phy_id, new_phy_id_valid, read_phy_id, map_table_valid, map_table_visible,
           ckpt_save_ready, ckpt_save_id, ckpt_busy, consistency_err,
    input  rename_phy_id, rename_phy_id_valid, rename_arch_id, rename_map, read_arch_id,
           commit_phy_id, commit_phy_id_valid, commit_map,
           release_phy_id, release_phy_id_valid, release_map,
           restore_new_phy_id, restore_old_phy_id, restore_map,
           tbl_valid_in, tbl_visible_in, tbl_restore,
           ckpt_save, ckpt_restore, ckpt_restore_id, ckpt_free, ckpt_free_id
  );
endinterface

// File: rtl/rat_ckpt.sv
// Register alias table with visible/committed views and CKPT_NUM visible-vector snapshots.
// Optional feature macro: RAT_CONSISTENCY_CHECK_EN (sticky registered map consistency check).
module rat_ckpt #(
  parameter int ARCH_REG_NUM  = 32,
  parameter int PHY_REG_NUM   = 64,
  parameter int RENAME_WIDTH  = 4,
  parameter int COMMIT_WIDTH  = 4,
  parameter int READ_PORT_NUM = 3,
  parameter int CKPT_NUM      = 4
) (
  input  logic      clk,
  input  logic      rst,
  rat_ckpt_if.slave rat
);
  localparam int AW     = $clog2(ARCH_REG_NUM);
  localparam int PW     = $clog2(PHY_REG_NUM);
  localparam int CW     = $clog2(CKPT_NUM);
  localparam int RD_NUM = RENAME_WIDTH * READ_PORT_NUM;

  logic [PHY_REG_NUM-1:0]    valid_q, visible_q, commit_q;
  logic [AW-1:0]             map_q  [PHY_REG_NUM];
  logic [PHY_REG_NUM-1:0]    snap_q [CKPT_NUM];
  logic [CKPT_NUM-1:0]       busy_q;

  logic [PHY_REG_NUM-1:0]    valid_n, visible_n, commit_n;
  logic [AW-1:0]             map_n  [PHY_REG_NUM];
  logic [CKPT_NUM-1:0]       busy_n;
  logic                      crest_ok, save_ok, save_ready;
  logic [CW-1:0]             save_id;

  logic [RENAME_WIDTH*PW-1:0] alloc_id;
  logic [RENAME_WIDTH-1:0]    alloc_vld;
  logic [PHY_REG_NUM-1:0]     alloc_taken;
  logic [RD_NUM*PW-1:0]       rd_phy;
  logic [AW-1:0]              rd_arch;
  logic [PW-1:0]              cp, ph;
  logic [AW-1:0]              ar;

  // Free-list scan: lane k claims the k-th lowest invalid phys.
  always_comb begin
    alloc_id    = '0;
    alloc_vld   = '0;
    alloc_taken = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      for (int p = 0; p < PHY_REG_NUM; p++) begin
        if (!valid_q[p] && !alloc_taken[p] && !alloc_vld[k]) begin
          alloc_id[k*PW +: PW] = PW'(p);
          alloc_vld[k]         = 1'b1;
          alloc_taken[p]       = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rd_phy  = '0;
    rd_arch = '0;
    for (int r = 0; r < RD_NUM; r++) begin
      rd_arch = rat.read_arch_id[r*AW +: AW];
      for (int p = PHY_REG_NUM-1; p >= 0; p--) begin
        if (rd_arch != '0 && valid_q[p] && visible_q[p] && map_q[p] == rd_arch)
          rd_phy[r*PW +: PW] = PW'(p);
      end
    end
  end

  always_comb begin
    save_id    = '0;
    save_ready = 1'b0;
    for (int c = CKPT_NUM-1; c >= 0; c--) begin
      if (!busy_q[c]) begin
        save_id    = CW'(c);
        save_ready = 1'b1;
      end
    end
  end

  // Operations are layered lowest priority first so later ones overwrite earlier ones.
  always_comb begin
    valid_n   = valid_q;
    visible_n = visible_q;
    commit_n  = commit_q;
    map_n     = map_q;
    busy_n    = busy_q;
    cp        = '0;
    ph        = '0;
    ar        = '0;
    crest_ok  = rat.ckpt_restore && busy_q[rat.ckpt_restore_id];
    save_ok   = rat.ckpt_save && save_ready && !crest_ok;

    if (rat.commit_map && !crest_ok) begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (rat.commit_phy_id_valid[l]) begin
          cp = rat.commit_phy_id[l*PW +: PW];
          for (int p = 0; p < PHY_REG_NUM; p++)
            if (PW'(p) != cp && map_n[p] == map_n[cp]) commit_n[p] = 1'b0;
          commit_n[cp] = 1'b1;
        end
      end
    end

    if (rat.release_map) begin
      for (int l = 0; l < COMMIT_WIDTH; l++) begin
        if (rat.release_phy_id_valid[l]) begin
          cp            = rat.release_phy_id[l*PW +: PW];
          valid_n[cp]   = 1'b0;
          visible_n[cp] = 1'b0;
          commit_n[cp]  = 1'b0;
        end
      end
    end

    if (rat.rename_map && !crest_ok) begin
      for (int l = 0; l < RENAME_WIDTH; l++) begin
        if (rat.rename_phy_id_valid[l]) begin
          ph = rat.rename_phy_id[l*PW +: PW];
          ar = rat.rename_arch_id[l*AW +: AW];
          for (int p = 0; p < PHY_REG_NUM; p++)
            if (PW'(p) != ph && map_n[p] == ar) visible_n[p] = 1'b0;
          valid_n[ph]   = 1'b1;
          visible_n[ph] = 1'b1;
          commit_n[ph]  = 1'b0;
          map_n[ph]     = ar;
        end
      end
    end

    if (rat.restore_map) begin
      valid_n[rat.restore_new_phy_id]   = 1'b0;
      visible_n[rat.restore_new_phy_id] = 1'b0;
      valid_n[rat.restore_old_phy_id]   = 1'b1;
      visible_n[rat.restore_old_phy_id] = 1'b1;
    end

    if (crest_ok) begin
      visible_n                    = snap_q[rat.ckpt_restore_id] & valid_n;
      busy_n[rat.ckpt_restore_id]  = 1'b0;
    end

    if (rat.tbl_restore) begin
      valid_n   = rat.tbl_valid_in;
      visible_n = rat.tbl_visible_in;
    end

    if (rat.ckpt_free) busy_n[rat.ckpt_free_id] = 1'b0;
    if (save_ok)       busy_n[save_id]          = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int p = 0; p < PHY_REG_NUM; p++) begin
        valid_q[p]   <= (p >= 1 && p < ARCH_REG_NUM);
        visible_q[p] <= (p >= 1 && p < ARCH_REG_NUM);
        commit_q[p]  <= (p >= 1 && p < ARCH_REG_NUM);
        map_q[p]     <= (p < ARCH_REG_NUM) ? AW'(p) : '0;
      end
      busy_q <= '0;
    end else begin
      valid_q   <= valid_n;
      visible_q <= visible_n;
      commit_q  <= commit_n;
      map_q     <= map_n;
      busy_q    <= busy_n;
      if (save_ok) snap_q[save_id] <= visible_n;
    end
  end

`ifdef RAT_CONSISTENCY_CHECK_EN
  logic err_q;

  // A selected set is consistent when every nonzero arch is claimed by exactly one phys.
  function automatic logic map_bad(input logic [PHY_REG_NUM-1:0] sel,
                                   input logic [AW-1:0]          mp [PHY_REG_NUM]);
    logic [(1<<AW)-1:0] seen;
    logic               bad;
    seen = '0;
    bad  = 1'b0;
    for (int p = 0; p < PHY_REG_NUM; p++) begin
      if (sel[p]) begin
        if (mp[p] == '0 || seen[mp[p]]) bad = 1'b1;
        seen[mp[p]] = 1'b1;
      end
    end
    for (int a = 1; a < (1 << AW); a++)
      if (seen[a] != (a < ARCH_REG_NUM)) bad = 1'b1;
    return bad;
  endfunction

  always_ff @(posedge clk) begin
    if (!rst)
      err_q <= 1'b0;
    else if (map_bad(valid_q & visible_q, map_q) || map_bad(valid_q & commit_q, map_q))
      err_q <= 1'b1;
  end

  assign rat.consistency_err = err_q;
`else
  assign rat.consistency_err = 1'b0;
`endif

  assign rat.new_phy_id        = alloc_id;
  assign rat.new_phy_id_valid  = alloc_vld;
  assign rat.read_phy_id       = rd_phy;
  assign rat.map_table_valid   = valid_q;
  assign rat.map_table_visible = visible_q;
  assign rat.ckpt_save_ready   = save_ready;
  assign rat.ckpt_save_id      = save_id;
  assign rat.ckpt_busy         = busy_q;
endmodule

// File: tb/tb_rat_ckpt.sv
// Bench for rat_ckpt: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against an array-based model of the alias-table rules.
module tb_rat_ckpt;
  localparam int A   = 32;
  localparam int P   = 64;
  localparam int RW  = 4;
  localparam int CMW = 4;
  localparam int RP  = 3;
  localparam int CK  = 4;
  localparam int AW  = 5;
  localparam int PW  = 6;
  localparam int RD  = RW * RP;

  logic clk;
  logic rst;
  bit   chk_en;
  int   checks;
  int   failures;

  bit [P-1:0]  m_valid, m_vis, m_cmt;
  int          m_map  [P];
  bit [P-1:0]  m_snap [CK];
  bit [CK-1:0] m_busy;
  bit          m_err;

  rat_ckpt_if #(.ARCH_REG_NUM(A), .PHY_REG_NUM(P), .RENAME_WIDTH(RW), .COMMIT_WIDTH(CMW),
                .READ_PORT_NUM(RP), .CKPT_NUM(CK)) bus ();

  rat_ckpt #(.ARCH_REG_NUM(A), .PHY_REG_NUM(P), .RENAME_WIDTH(RW), .COMMIT_WIDTH(CMW),
             .READ_PORT_NUM(RP), .CKPT_NUM(CK)) dut (.clk(clk), .rst(rst), .rat(bus));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_valid = '0;
    m_vis   = '0;
    m_cmt   = '0;
    for (int p = 0; p < P; p++) begin
      m_map[p] = (p < A) ? p : 0;
      if (p >= 1 && p < A) begin
        m_valid[p] = 1'b1;
        m_vis[p]   = 1'b1;
        m_cmt[p]   = 1'b1;
      end
    end
    m_busy = '0;
    m_err  = 1'b0;
  endfunction

  function automatic bit m_bad(input bit [P-1:0] sel);
    int cnt [A];
    int tot;
    bit bad;
    tot = 0;
    bad = 1'b0;
    for (int a = 0; a < A; a++) cnt[a] = 0;
    for (int p = 0; p < P; p++) begin
      if (sel[p]) begin
        tot++;
        if (m_map[p] > 0 && m_map[p] < A) cnt[m_map[p]]++;
        else bad = 1'b1;
      end
    end
    if (tot != A - 1) bad = 1'b1;
    for (int a = 1; a < A; a++) if (cnt[a] != 1) bad = 1'b1;
    return bad;
  endfunction

  function automatic int m_free_slot();
    for (int s = 0; s < CK; s++) if (!m_busy[s]) return s;
    return -1;
  endfunction

  // Apply one cycle of the table rules, lowest priority first.
  function automatic void model_step();
    bit crest, save;
    int sid, c, a, rid;
    if (!rst) begin
      model_reset();
      return;
    end
`ifdef RAT_CONSISTENCY_CHECK_EN
    if (m_bad(m_valid & m_vis) || m_bad(m_valid & m_cmt)) m_err = 1'b1;
`endif
    sid   = m_free_slot();
    rid   = int'(bus.ckpt_restore_id);
    crest = bus.ckpt_restore && m_busy[rid];
    save  = bus.ckpt_save && (sid >= 0) && !crest;
    if (bus.commit_map && !crest)
      for (int l = 0; l < CMW; l++)
        if (bus.commit_phy_id_valid[l]) begin
          c = int'(bus.commit_phy_id[l*PW +: PW]);
          for (int p = 0; p < P; p++) if (p != c && m_map[p] == m_map[c]) m_cmt[p] = 1'b0;
          m_cmt[c] = 1'b1;
        end
    if (bus.release_map)
      for (int l = 0; l < CMW; l++)
        if (bus.release_phy_id_valid[l]) begin
          c = int'(bus.release_phy_id[l*PW +: PW]);
          m_valid[c] = 1'b0;
          m_vis[c]   = 1'b0;
          m_cmt[c]   = 1'b0;
        end
    if (bus.rename_map && !crest)
      for (int l = 0; l < RW; l++)
        if (bus.rename_phy_id_valid[l]) begin
          c = int'(bus.rename_phy_id[l*PW +: PW]);
          a = int'(bus.rename_arch_id[l*AW +: AW]);
          for (int p = 0; p < P; p++) if (p != c && m_map[p] == a) m_vis[p] = 1'b0;
          m_valid[c] = 1'b1;
          m_vis[c]   = 1'b1;
          m_cmt[c]   = 1'b0;
          m_map[c]   = a;
        end
    if (bus.restore_map) begin
      m_valid[int'(bus.restore_new_phy_id)] = 1'b0;
      m_vis[int'(bus.restore_new_phy_id)]   = 1'b0;
      m_valid[int'(bus.restore_old_phy_id)] = 1'b1;
      m_vis[int'(bus.restore_old_phy_id)]   = 1'b1;
    end
    if (crest) begin
      m_vis       = m_snap[rid] & m_valid;
      m_busy[rid] = 1'b0;
    end
    if (bus.tbl_restore) begin
      m_valid = bus.tbl_valid_in;
      m_vis   = bus.tbl_visible_in;
    end
    if (bus.ckpt_free) m_busy[int'(bus.ckpt_free_id)] = 1'b0;
    if (save) begin
      m_busy[sid] = 1'b1;
      m_snap[sid] = m_vis;
    end
  endfunction

  always @(posedge clk) model_step();

  task automatic compare_all();
    logic [RW*PW-1:0] e_new;
    logic [RW-1:0]    e_newv;
    logic [RD*PW-1:0] e_rd;
    int fq[$];
    int a, sid;
    e_new  = '0;
    e_newv = '0;
    e_rd   = '0;
    for (int p = 0; p < P; p++) if (!m_valid[p]) fq.push_back(p);
    for (int k = 0; k < RW; k++)
      if (k < fq.size()) begin
        e_new[k*PW +: PW] = PW'(fq[k]);
        e_newv[k]         = 1'b1;
      end
    for (int r = 0; r < RD; r++) begin
      a = int'(bus.read_arch_id[r*AW +: AW]);
      if (a != 0)
        for (int p = P - 1; p >= 0; p--)
          if (m_valid[p] && m_vis[p] && m_map[p] == a) e_rd[r*PW +: PW] = PW'(p);
    end
    sid = m_free_slot();
    chk("new_phy_id", bus.new_phy_id, e_new);
    chk("new_phy_id_valid", bus.new_phy_id_valid, e_newv);
    chk("read_phy_id", bus.read_phy_id, e_rd);
    chk("map_table_valid", bus.map_table_valid, m_valid);
    chk("map_table_visible", bus.map_table_visible, m_vis);
    chk("ckpt_busy", bus.ckpt_busy, m_busy);
    chk("ckpt_save_ready", bus.ckpt_save_ready, sid >= 0);
    if (sid >= 0) chk("ckpt_save_id", bus.ckpt_save_id, sid);
    chk("consistency_err", bus.consistency_err, m_err);
  endtask

  always @(negedge clk) if (chk_en) compare_all();

  task automatic clr_in();
    bus.rename_phy_id = '0;  bus.rename_phy_id_valid = '0; bus.rename_arch_id = '0;
    bus.rename_map = 1'b0;   bus.read_arch_id = '0;
    bus.commit_phy_id = '0;  bus.commit_phy_id_valid = '0; bus.commit_map = 1'b0;
    bus.release_phy_id = '0; bus.release_phy_id_valid = '0; bus.release_map = 1'b0;
    bus.restore_new_phy_id = '0; bus.restore_old_phy_id = '0; bus.restore_map = 1'b0;
    bus.tbl_valid_in = '0;   bus.tbl_visible_in = '0;   bus.tbl_restore = 1'b0;
    bus.ckpt_save = 1'b0;    bus.ckpt_restore = 1'b0;   bus.ckpt_restore_id = '0;
    bus.ckpt_free = 1'b0;    bus.ckpt_free_id = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    clr_in();
    #1;
  endtask

  task automatic rand_cycle();
    int fq[$];
    rst = ($urandom_range(0, 299) != 0);
    for (int p = 0; p < P; p++) if (!m_valid[p]) fq.push_back(p);
    bus.rename_map = ($urandom_range(0, 1) != 0);
    for (int l = 0; l < RW; l++) begin
      bus.rename_arch_id[l*AW +: AW] = AW'($urandom_range(1, A - 1));
      if (l < fq.size() && $urandom_range(0, 7) != 0)
        bus.rename_phy_id[l*PW +: PW] = PW'(fq[l]);
      else
        bus.rename_phy_id[l*PW +: PW] = PW'($urandom_range(0, P - 1));
      bus.rename_phy_id_valid[l] = ($urandom_range(0, 3) != 0);
    end
    bus.commit_map  = ($urandom_range(0, 1) != 0);
    bus.release_map = ($urandom_range(0, 3) == 0);
    for (int l = 0; l < CMW; l++) begin
      bus.commit_phy_id[l*PW +: PW]  = PW'($urandom_range(0, P - 1));
      bus.commit_phy_id_valid[l]     = ($urandom_range(0, 1) != 0);
      bus.release_phy_id[l*PW +: PW] = PW'($urandom_range(0, P - 1));
      bus.release_phy_id_valid[l]    = ($urandom_range(0, 3) == 0);
    end
    for (int r = 0; r < RD; r++) bus.read_arch_id[r*AW +: AW] = AW'($urandom_range(0, A - 1));
    bus.restore_map        = ($urandom_range(0, 15) == 0);
    bus.restore_new_phy_id = PW'($urandom_range(0, P - 1));
    bus.restore_old_phy_id = PW'($urandom_range(0, P - 1));
    bus.tbl_restore        = ($urandom_range(0, 63) == 0);
    bus.tbl_valid_in       = {$urandom, $urandom};
    bus.tbl_visible_in     = {$urandom, $urandom};
    bus.ckpt_save          = ($urandom_range(0, 3) == 0);
    bus.ckpt_restore       = ($urandom_range(0, 5) == 0);
    bus.ckpt_restore_id    = 2'($urandom_range(0, CK - 1));
    bus.ckpt_free          = ($urandom_range(0, 7) == 0);
    bus.ckpt_free_id       = 2'($urandom_range(0, CK - 1));
    cyc();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    chk_en   = 1'b0;
    rst      = 1'b0;
    clr_in();
    cyc();
    cyc();
    chk_en = 1'b1;

    chk("rst_new_phy_id", bus.new_phy_id, {6'd34, 6'd33, 6'd32, 6'd0});
    chk("rst_new_phy_id_valid", bus.new_phy_id_valid, 4'hf);
    chk("rst_valid", bus.map_table_valid, 64'h00000000_FFFFFFFE);
    chk("rst_visible", bus.map_table_visible, 64'h00000000_FFFFFFFE);
    chk("rst_busy", bus.ckpt_busy, 4'h0);
    chk("rst_err", bus.consistency_err, 1'b0);
    rst = 1'b1;

    bus.rename_map = 1'b1;
    bus.rename_phy_id = {6'd34, 6'd33, 6'd32, 6'd0};
    bus.rename_phy_id_valid = 4'hf;
    bus.rename_arch_id = {5'd4, 5'd3, 5'd2, 5'd1};
    cyc();
    bus.commit_map = 1'b1;
    bus.commit_phy_id = {6'd34, 6'd33, 6'd32, 6'd0};
    bus.commit_phy_id_valid = 4'hf;
    cyc();
    bus.read_arch_id = {40'd0, 5'd4, 5'd3, 5'd2, 5'd1};
    #1;
    chk("lookup_arch1_4", bus.read_phy_id, {48'd0, 6'd34, 6'd33, 6'd32, 6'd0});
    chk("visible_after_rename", bus.map_table_visible, 64'h00000007_FFFFFFE1);
    chk("valid_after_rename", bus.map_table_valid, 64'h00000007_FFFFFFFF);
    chk("err_after_commit", bus.consistency_err, 1'b0);

    chk("save_id_first", bus.ckpt_save_id, 2'd0);
    bus.ckpt_save = 1'b1;
    cyc();
    chk("busy_after_save", bus.ckpt_busy, 4'h1);
    chk("alloc_after_save", bus.new_phy_id, {6'd38, 6'd37, 6'd36, 6'd35});
    bus.rename_map = 1'b1;
    bus.rename_phy_id = {18'd0, 6'd35};
    bus.rename_phy_id_valid = 4'h1;
    bus.rename_arch_id = {15'd0, 5'd5};
    cyc();
    bus.read_arch_id = {55'd0, 5'd5};
    #1;
    chk("lookup_arch5_renamed", bus.read_phy_id, 72'd35);
    bus.ckpt_restore = 1'b1;
    bus.ckpt_restore_id = 2'd0;
    cyc();
    bus.read_arch_id = {55'd0, 5'd5};
    #1;
    chk("lookup_arch5_restored", bus.read_phy_id, 72'd5);
    chk("busy_after_restore", bus.ckpt_busy, 4'h0);

    for (int i = 0; i < 4; i++) begin
      bus.ckpt_save = 1'b1;
      cyc();
    end
    chk("ready_when_full", bus.ckpt_save_ready, 1'b0);
    chk("busy_full", bus.ckpt_busy, 4'hf);
    bus.ckpt_save = 1'b1;
    cyc();
    chk("busy_fifth_save", bus.ckpt_busy, 4'hf);
    bus.ckpt_free = 1'b1;
    bus.ckpt_free_id = 2'd2;
    cyc();
    chk("save_id_after_free", bus.ckpt_save_id, 2'd2);
    chk("busy_after_free", bus.ckpt_busy, 4'hb);

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.release_map = 1'b1;
    bus.release_phy_id = {6'd4, 6'd3, 6'd2, 6'd1};
    bus.release_phy_id_valid = 4'hf;
    cyc();
    chk("valid_after_release", bus.map_table_valid, 64'h00000000_FFFFFFE0);
    chk("alloc_after_release", bus.new_phy_id, {6'd3, 6'd2, 6'd1, 6'd0});

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    bus.restore_map = 1'b1;
    bus.restore_new_phy_id = 6'd1;
    bus.restore_old_phy_id = 6'd0;
    cyc();
    chk("restore_valid_lo", bus.map_table_valid[1:0], 2'b01);
    chk("restore_visible_lo", bus.map_table_visible[1:0], 2'b01);
    bus.tbl_restore = 1'b1;
    bus.tbl_valid_in = 64'habdc71259acd1587;
    bus.tbl_visible_in = 64'habdc71259acd1587;
    cyc();
    chk("tbl_valid", bus.map_table_valid, 64'habdc71259acd1587);
    chk("tbl_visible", bus.map_table_visible, 64'habdc71259acd1587);

    rst = 1'b0;
    cyc();
    rst = 1'b1;
    for (int i = 0; i < 3000; i++) rand_cycle();
    rst = 1'b1;
    cyc();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
